// File: rtl/turn_tracker.sv
// turn_tracker: per-turn phase and action/buy/coin bookkeeping for a deck-building card game.
// Rev 1.0
`default_nettype none

module turn_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_turn,
  input  logic       play_valid,
  input  logic       play_is_action,
  input  logic [4:0] gold,
  input  logic [2:0] buy,
  input  logic [2:0] action,
  input  logic [2:0] draw,
  input  logic       buy_req,
  input  logic [3:0] buy_cost,
  input  logic       end_phase,
  output logic [1:0] phase,
  output logic [3:0] actions_left,
  output logic [3:0] buys_left,
  output logic [5:0] coins,
  output logic       play_ack,
  output logic       play_nack,
  output logic       buy_ack,
  output logic       buy_nack,
  output logic       draw_req,
  output logic [2:0] draw_count,
  output logic       turn_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACTION  = 2'b01,
    BUY     = 2'b10,
    CLEANUP = 2'b11
  } state_t;

  state_t     state, state_n;
  logic [3:0] actions_n, buys_n;
  logic [5:0] coins_n;
  logic       play_ack_n, play_nack_n, buy_ack_n, buy_nack_n;
  logic       draw_req_n, turn_done_n;
  logic [2:0] draw_count_n;

  // Saturating sums; the action sum is only used when actions_left > 0.
  logic [4:0] act_sum;
  logic [4:0] buy_sum;
  logic [6:0] coin_sum;
  logic [3:0] act_sat, buy_sat;
  logic [5:0] coin_sat;
  logic       can_buy;

  assign act_sum  = {1'b0, actions_left} + {2'b00, action} - 5'd1;
  assign buy_sum  = {1'b0, buys_left} + {2'b00, buy};
  assign coin_sum = {1'b0, coins} + {2'b00, gold};
  assign act_sat  = (act_sum > 5'd15) ? 4'd15 : act_sum[3:0];
  assign buy_sat  = (buy_sum > 5'd15) ? 4'd15 : buy_sum[3:0];
  assign coin_sat = (coin_sum > 7'd63) ? 6'd63 : coin_sum[5:0];
  assign can_buy  = (buys_left != 4'd0) && (coins >= {2'b00, buy_cost});

  assign phase = state;

  always_comb begin
    state_n      = state;
    actions_n    = actions_left;
    buys_n       = buys_left;
    coins_n      = coins;
    play_ack_n   = 1'b0;
    play_nack_n  = 1'b0;
    buy_ack_n    = 1'b0;
    buy_nack_n   = 1'b0;
    draw_req_n   = 1'b0;
    draw_count_n = 3'd0;
    turn_done_n  = 1'b0;

    case (state)
      IDLE: begin
        play_nack_n = play_valid;
        buy_nack_n  = buy_req;
        if (start_turn) begin
          state_n   = ACTION;
          actions_n = 4'd1;
          buys_n    = 4'd1;
          coins_n   = 6'd0;
        end
      end

      ACTION: begin
        if (end_phase) begin
          state_n     = BUY;
          play_nack_n = play_valid;
          buy_nack_n  = buy_req;
        end else if (play_valid) begin
          buy_nack_n = buy_req;
          if (play_is_action && (actions_left != 4'd0)) begin
            play_ack_n = 1'b1;
            actions_n  = act_sat;
            buys_n     = buy_sat;
            coins_n    = coin_sat;
            if (draw != 3'd0) begin
              draw_req_n   = 1'b1;
              draw_count_n = draw;
            end
          end else begin
            play_nack_n = 1'b1;
          end
        end else if (buy_req) begin
          buy_nack_n = 1'b1;
        end
      end

      BUY: begin
        if (end_phase) begin
          // Cleanup outputs are produced on entry so they coincide with phase=CLEANUP.
          state_n      = CLEANUP;
          play_nack_n  = play_valid;
          buy_nack_n   = buy_req;
          turn_done_n  = 1'b1;
          draw_req_n   = 1'b1;
          draw_count_n = 3'd5;
          actions_n    = 4'd0;
          buys_n       = 4'd0;
          coins_n      = 6'd0;
        end else if (play_valid) begin
          buy_nack_n = buy_req;
          if (!play_is_action) begin
            play_ack_n = 1'b1;
            coins_n    = coin_sat;
          end else begin
            play_nack_n = 1'b1;
          end
        end else if (buy_req) begin
          if (can_buy) begin
            buy_ack_n = 1'b1;
            coins_n   = coins - {2'b00, buy_cost};
            buys_n    = buys_left - 4'd1;
          end else begin
            buy_nack_n = 1'b1;
          end
        end
      end

      default: begin
        state_n     = IDLE;
        play_nack_n = play_valid;
        buy_nack_n  = buy_req;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      actions_left <= 4'd0;
      buys_left    <= 4'd0;
      coins        <= 6'd0;
      play_ack     <= 1'b0;
      play_nack    <= 1'b0;
      buy_ack      <= 1'b0;
      buy_nack     <= 1'b0;
      draw_req     <= 1'b0;
      draw_count   <= 3'd0;
      turn_done    <= 1'b0;
    end else begin
      state        <= state_n;
      actions_left <= actions_n;
      buys_left    <= buys_n;
      coins        <= coins_n;
      play_ack     <= play_ack_n;
      play_nack    <= play_nack_n;
      buy_ack      <= buy_ack_n;
      buy_nack     <= buy_nack_n;
      draw_req     <= draw_req_n;
      draw_count   <= draw_count_n;
      turn_done    <= turn_done_n;
    end
  end

endmodule

`default_nettype wire
